gpu_mem_arbiter: RTL and testbench
==================================

Name: gpu_mem_arbiter

Overview:
N-port parametrised successor to the two-port GPU memory data mux. It latches single-clock read/write strobes from PORTS requesters and arbitrates them round-robin onto one GPU memory command bus, issuing at most one command per clock. Read returns are routed back to the originating port through an in-order tag FIFO, so multiple reads can be outstanding. It sits between the host/blitter/display requesters and the GPU RAM port.

Parameters:
PORTS, 4, number of requester ports (2..8)
ADDR_W, 20, address width
DATA_W, 8, data width
TAG_DEPTH, 8, max outstanding reads (power of 2)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
wr_ena  in  PORTS  per-port write strobe, 1-clock pulse
rd_req  in  PORTS  per-port read strobe, 1-clock pulse
address  in  PORTS*ADDR_W  port i at [i*ADDR_W +: ADDR_W]
data_in  in  PORTS*DATA_W  port i write data, same packing
port_busy  out  PORTS  port has a pending, not-yet-issued command
gpu_rd_rdy  in  1  high 1 clock when gpu_data_in valid
gpu_data_in  in  DATA_W  read data from GPU RAM
gpu_wr_ena  out  1  write strobe, 1 clock
gpu_rd_req  out  1  read strobe, 1 clock
gpu_address  out  ADDR_W  command address
gpu_data_out  out  DATA_W  write data
rd_rdy_out  out  PORTS  per-port read-data-valid pulse
data_out  out  PORTS*DATA_W  per-port read data, held until next return to that port
rd_outstanding  out  $clog2(TAG_DEPTH+1)  reads issued, not yet returned
orphan_rdy  out  1  sticky: gpu_rd_rdy seen with tag FIFO empty

Behaviour:
- Reset (reset low, async): all outputs 0, pending registers cleared, tag FIFO emptied, RR pointer = PORTS-1 (port 0 first).
- Capture: strobe on port i while port_busy[i]=0 loads pending reg {op, address, data}; port_busy[i] high from next cycle. Strobes while busy are ignored. wr_ena and rd_req together: write captured, read dropped.
- Arbitration, each clock: eligible = pending writes, plus pending reads only if tag FIFO not full. Grant first eligible port searching from RR pointer+1, wrapping modulo PORTS; pointer <= granted port. Grant clears pending (port_busy low next cycle).
- Issue: granted command registered onto gpu_* outputs; gpu_wr_ena/gpu_rd_req high exactly 1 clock; gpu_address/gpu_data_out hold last value when idle. Latency: strobe in cycle n, idle arbiter -> gpu strobe in cycle n+2.
- Read issue pushes granted port index into tag FIFO. Full FIFO blocks read issue even if a pop occurs the same cycle; writes still issue.
- Return: gpu_rd_rdy in cycle m pops FIFO head p; cycle m+1: rd_rdy_out[p]=1 for 1 clock, data_out[p] <= gpu_data_in. Returns strictly in issue order.
- Push and pop same cycle: count unchanged.
- gpu_rd_rdy with FIFO empty: no rd_rdy_out pulse, data_out unchanged, orphan_rdy <= 1 until reset.
- Reset mid-operation discards outstanding tags; late returns after reset set orphan_rdy.
- rd_outstanding = FIFO occupancy, 0..TAG_DEPTH.

Optional Feature:
GPU_ARB_FIXED_PRIO_EN: when defined, RR pointer removed; lowest-index eligible port always wins (port 0 highest, for display refresh). Undefined: round-robin as above. Capture, tag FIFO, return path identical in both.

Test Plan:
- Single port 2 rd_req, addr 0x12345, idle -> gpu_rd_req cycle n+2 addr 0x12345; gpu_rd_rdy data 0xA5 -> rd_rdy_out=0b0100, port 2 data_out=0xA5 next cycle.
- All 4 ports write same cycle -> gpu_wr_ena on 4 consecutive clocks, order 0,1,2,3; repeat -> order 0,1,2,3 again (RR); with GPU_ARB_FIXED_PRIO_EN and port 0 re-requesting when free, port 0 served before 3.
- 9 reads (TAG_DEPTH=8), no returns -> 8 gpu_rd_req, rd_outstanding=8, 9th port busy; one gpu_rd_rdy -> 9th issued next arbitration.
- Reads from ports 3,1,0 outstanding, returns 0x11,0x22,0x33 -> rd_rdy_out pulses 3,1,0 with those data.
- gpu_rd_rdy with rd_outstanding=0 -> no pulse, orphan_rdy=1 until reset low.
- Same-cycle wr_ena+rd_req on port 1 -> only gpu_wr_ena issued; strobe on busy port ignored.

Source files
------------

// File: rtl/gpu_mem_arbiter_if.sv
// GPU RAM command bus: the arbiter is the master, the GPU RAM port
// the slave. Commands flow out; read data and its valid flow back.
interface gpu_mem_arbiter_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 8
);
    logic              gpu_wr_ena;
    logic              gpu_rd_req;
    logic [ADDR_W-1:0] gpu_address;
    logic [DATA_W-1:0] gpu_data_out;
    logic              gpu_rd_rdy;
    logic [DATA_W-1:0] gpu_data_in;

    modport master (
        output gpu_wr_ena,
        output gpu_rd_req,
        output gpu_address,
        output gpu_data_out,
        input  gpu_rd_rdy,
        input  gpu_data_in
    );

    modport slave (
        input  gpu_wr_ena,
        input  gpu_rd_req,
        input  gpu_address,
        input  gpu_data_out,
        output gpu_rd_rdy,
        output gpu_data_in
    );
endinterface

// File: rtl/gpu_mem_arbiter.sv
// N-port round-robin GPU memory arbiter with in-order read tag FIFO.
// Define GPU_ARB_FIXED_PRIO_EN for fixed priority (port 0 highest).
module gpu_mem_arbiter #(
    parameter int PORTS     = 4,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 8,
    parameter int TAG_DEPTH = 8,
    localparam int CW       = $clog2(TAG_DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [PORTS-1:0]        wr_ena,
    input  logic [PORTS-1:0]        rd_req,
    input  logic [PORTS*ADDR_W-1:0] address,
    input  logic [PORTS*DATA_W-1:0] data_in,
    output logic [PORTS-1:0]        port_busy,
    gpu_mem_arbiter_if.master       gpu,
    output logic [PORTS-1:0]        rd_rdy_out,
    output logic [PORTS*DATA_W-1:0] data_out,
    output logic [CW-1:0]           rd_outstanding,
    output logic                    orphan_rdy
);
    localparam int PW = $clog2(PORTS);
    localparam int TW = $clog2(TAG_DEPTH);

    logic [PORTS-1:0]  pend_vld;
    logic [PORTS-1:0]  pend_wr;
    logic [ADDR_W-1:0] pend_addr [PORTS];
    logic [DATA_W-1:0] pend_data [PORTS];
    logic [PORTS-1:0]  elig;
    logic              gnt_vld;
    logic [PW-1:0]     gnt;
    logic [PW-1:0]     tag_mem [TAG_DEPTH];
    logic [TW-1:0]     wr_ptr;
    logic [TW-1:0]     rd_ptr;
    logic [CW-1:0]     tag_cnt;
    logic              tag_full;
    logic              push;
    logic              pop;
    logic              orphan_hit;
    logic [PW-1:0]     head;

    assign port_busy      = pend_vld;
    assign rd_outstanding = tag_cnt;
    assign tag_full       = (tag_cnt == CW'(TAG_DEPTH));
    // Reads need a free tag slot; writes never wait on the FIFO.
    assign elig       = pend_vld & (pend_wr | {PORTS{!tag_full}});
    assign push       = gnt_vld && !pend_wr[gnt];
    assign pop        = gpu.gpu_rd_rdy && (tag_cnt != '0);
    assign orphan_hit = gpu.gpu_rd_rdy && (tag_cnt == '0);
    assign head       = tag_mem[rd_ptr];

`ifdef GPU_ARB_FIXED_PRIO_EN
    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (elig[PW'(i)]) begin
                gnt_vld = 1'b1;
                gnt     = PW'(i);
            end
        end
    end
`else
    logic [PW-1:0] rr_ptr;

    always_comb begin
        int            idx;
        logic [PW-1:0] pi;
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = 0;
        pi      = '0;
        for (int k = 1; k <= PORTS; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= PORTS) idx = idx - PORTS;
            pi = PW'(idx);
            if (!gnt_vld && elig[pi]) begin
                gnt_vld = 1'b1;
                gnt     = pi;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       rr_ptr <= PW'(PORTS - 1);
        else if (gnt_vld) rr_ptr <= gnt;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_vld <= '0;
            pend_wr  <= '0;
            for (int i = 0; i < PORTS; i++) begin
                pend_addr[i] <= '0;
                pend_data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PORTS; i++) begin
                if (!pend_vld[i] && (wr_ena[i] || rd_req[i])) begin
                    pend_vld[i]  <= 1'b1;
                    pend_wr[i]   <= wr_ena[i];
                    pend_addr[i] <= address[i*ADDR_W +: ADDR_W];
                    pend_data[i] <= data_in[i*DATA_W +: DATA_W];
                end else if (gnt_vld && gnt == PW'(i)) begin
                    pend_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gpu.gpu_wr_ena   <= 1'b0;
            gpu.gpu_rd_req   <= 1'b0;
            gpu.gpu_address  <= '0;
            gpu.gpu_data_out <= '0;
        end else begin
            gpu.gpu_wr_ena <= gnt_vld && pend_wr[gnt];
            gpu.gpu_rd_req <= push;
            if (gnt_vld) begin
                gpu.gpu_address  <= pend_addr[gnt];
                gpu.gpu_data_out <= pend_data[gnt];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wr_ptr] <= gnt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      tag_cnt <= tag_cnt + 1'b1;
            else if (pop && !push) tag_cnt <= tag_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_rdy_out <= '0;
            data_out   <= '0;
            orphan_rdy <= 1'b0;
        end else begin
            rd_rdy_out <= '0;
            if (pop) begin
                rd_rdy_out[head]                 <= 1'b1;
                data_out[head*DATA_W +: DATA_W] <= gpu.gpu_data_in;
            end
            if (orphan_hit) orphan_rdy <= 1'b1;
        end
    end
endmodule

// File: tb/tb_gpu_mem_arbiter.sv
// Directed self-checking bench for gpu_mem_arbiter (4 ports, 8 tags).
// Expected values are hand-computed from the cycle-level behaviour.
module tb_gpu_mem_arbiter;
    localparam int PORTS     = 4;
    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 8;
    localparam int TAG_DEPTH = 8;
    localparam int CW        = $clog2(TAG_DEPTH + 1);

    logic                    clk = 1'b0;
    logic                    reset;
    logic [PORTS-1:0]        wr_ena;
    logic [PORTS-1:0]        rd_req;
    logic [PORTS*ADDR_W-1:0] address;
    logic [PORTS*DATA_W-1:0] data_in;
    logic [PORTS-1:0]        port_busy;
    logic [PORTS-1:0]        rd_rdy_out;
    logic [PORTS*DATA_W-1:0] data_out;
    logic [CW-1:0]           rd_outstanding;
    logic                    orphan_rdy;

    int n_cmp = 0;
    int n_err = 0;
    int n_rd;
    logic [19:0] exp_seq [5];

    gpu_mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    gpu_mem_arbiter #(
        .PORTS(PORTS), .ADDR_W(ADDR_W),
        .DATA_W(DATA_W), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_ena(wr_ena),
        .rd_req(rd_req),
        .address(address),
        .data_in(data_in),
        .port_busy(port_busy),
        .gpu(bus),
        .rd_rdy_out(rd_rdy_out),
        .data_out(data_out),
        .rd_outstanding(rd_outstanding),
        .orphan_rdy(orphan_rdy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wr_ena          = '0;
        rd_req          = '0;
        bus.gpu_rd_rdy  = 1'b0;
        bus.gpu_data_in = '0;
    endtask

    task automatic set_port(input int p, input logic [19:0] a,
                            input logic [7:0] d);
        address[p*ADDR_W +: ADDR_W] = a;
        data_in[p*DATA_W +: DATA_W] = d;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc();
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        reset   = 1'b0;
        address = '0;
        data_in = '0;
        clr();
        cyc();
        cyc();
        chk("rst_wr", 32'(bus.gpu_wr_ena), 32'h0);
        chk("rst_rd", 32'(bus.gpu_rd_req), 32'h0);
        chk("rst_addr", 32'(bus.gpu_address), 32'h0);
        chk("rst_busy", 32'(port_busy), 32'h0);
        chk("rst_cnt", 32'(rd_outstanding), 32'h0);
        chk("rst_orph", 32'(orphan_rdy), 32'h0);
        chk("rst_rdy", 32'(rd_rdy_out), 32'h0);
        chk("rst_dout", 32'(data_out), 32'h0);
        reset = 1'b1;
        cyc();

        // single read on port 2, latency n+2, return routed to port 2
        rd_req[2] = 1'b1;
        set_port(2, 20'h12345, 8'h00);
        cyc();
        clr();
        chk("p2_busy", 32'(port_busy), 32'h4);
        chk("p2_early", 32'(bus.gpu_rd_req), 32'h0);
        cyc();
        chk("p2_rdreq", 32'(bus.gpu_rd_req), 32'h1);
        chk("p2_addr", 32'(bus.gpu_address), 32'h12345);
        chk("p2_free", 32'(port_busy), 32'h0);
        chk("p2_cnt1", 32'(rd_outstanding), 32'h1);
        cyc();
        chk("p2_pulse1", 32'(bus.gpu_rd_req), 32'h0);
        chk("p2_hold", 32'(bus.gpu_address), 32'h12345);
        bus.gpu_rd_rdy  = 1'b1;
        bus.gpu_data_in = 8'hA5;
        cyc();
        clr();
        chk("p2_rdy", 32'(rd_rdy_out), 32'h4);
        chk("p2_data", 32'(data_out[23:16]), 32'hA5);
        chk("p2_cnt0", 32'(rd_outstanding), 32'h0);
        cyc();
        chk("p2_rdy1", 32'(rd_rdy_out), 32'h0);
        chk("p2_keep", 32'(data_out[23:16]), 32'hA5);

        // four simultaneous writes from a fresh pointer: 0,1,2,3
        do_reset();
        wr_ena = 4'hF;
        for (int i = 0; i < 4; i++)
            set_port(i, 20'h100 + 20'(i), 8'h10 + 8'(i));
        cyc();
        clr();
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("w1_ena", 32'(bus.gpu_wr_ena), 32'h1);
            chk("w1_addr", 32'(bus.gpu_address), 32'h100 + k);
            chk("w1_data", 32'(bus.gpu_data_out), 32'h10 + k);
        end
        cyc();
        chk("w1_idle", 32'(bus.gpu_wr_ena), 32'h0);
        chk("w1_busy", 32'(port_busy), 32'h0);

        // second round; port 0 re-requests as soon as it is free
`ifdef GPU_ARB_FIXED_PRIO_EN
        exp_seq = '{20'h200, 20'h201, 20'h2F0, 20'h202, 20'h203};
`else
        exp_seq = '{20'h200, 20'h201, 20'h202, 20'h203, 20'h2F0};
`endif
        wr_ena = 4'hF;
        for (int i = 0; i < 4; i++)
            set_port(i, 20'h200 + 20'(i), 8'(i));
        cyc();
        clr();
        for (int k = 0; k < 5; k++) begin
            cyc();
            clr();
            if (k == 0) begin
                wr_ena[0] = 1'b1;
                set_port(0, 20'h2F0, 8'hF0);
            end
            chk("w2_ena", 32'(bus.gpu_wr_ena), 32'h1);
            chk("w2_addr", 32'(bus.gpu_address), 32'(exp_seq[k]));
            chk("w2_data", 32'(bus.gpu_data_out),
                32'(exp_seq[k][7:0]));
        end
        cyc();
        chk("w2_idle", 32'(bus.gpu_wr_ena), 32'h0);

        // nine reads on port 0 with no returns: FIFO fills at eight
        n_rd = 0;
        for (int t = 0; t < 24; t++) begin
            clr();
            if (t % 2 == 0 && t < 18) begin
                rd_req[0] = 1'b1;
                set_port(0, 20'h300 + 20'(t / 2), 8'h00);
            end
            cyc();
            n_rd += int'(bus.gpu_rd_req);
        end
        clr();
        chk("f_nrd", 32'(n_rd), 32'h8);
        chk("f_cnt8", 32'(rd_outstanding), 32'h8);
        chk("f_busy", 32'(port_busy), 32'h1);
        wr_ena[0] = 1'b1;
        set_port(0, 20'h3FF, 8'hEE);
        cyc();
        clr();
        chk("f_ignbusy", 32'(port_busy), 32'h1);
        chk("f_nowr", 32'(bus.gpu_wr_ena), 32'h0);
        bus.gpu_rd_rdy  = 1'b1;
        bus.gpu_data_in = 8'h5A;
        cyc();
        clr();
        chk("f_rdy", 32'(rd_rdy_out), 32'h1);
        chk("f_data", 32'(data_out[7:0]), 32'h5A);
        chk("f_cnt7", 32'(rd_outstanding), 32'h7);
        chk("f_notyet", 32'(bus.gpu_rd_req), 32'h0);
        cyc();
        chk("f_9th", 32'(bus.gpu_rd_req), 32'h1);
        chk("f_9addr", 32'(bus.gpu_address), 32'h308);
        chk("f_9wr", 32'(bus.gpu_wr_ena), 32'h0);
        chk("f_cnt8b", 32'(rd_outstanding), 32'h8);
        chk("f_busy0", 32'(port_busy), 32'h0);
        for (int j = 0; j < 8; j++) begin
            bus.gpu_rd_rdy  = 1'b1;
            bus.gpu_data_in = 8'h60 + 8'(j);
            cyc();
        end
        clr();
        cyc();
        chk("f_drain", 32'(rd_outstanding), 32'h0);
        chk("f_noorph", 32'(orphan_rdy), 32'h0);
        chk("f_lastd", 32'(data_out[7:0]), 32'h67);

        // reads from ports 3,1,0 return in issue order
        rd_req[3] = 1'b1;
        set_port(3, 20'h503, 8'h00);
        cyc();
        clr();
        rd_req[1] = 1'b1;
        set_port(1, 20'h501, 8'h00);
        cyc();
        clr();
        rd_req[0] = 1'b1;
        set_port(0, 20'h500, 8'h00);
        cyc();
        clr();
        cyc();
        chk("o_cnt3", 32'(rd_outstanding), 32'h3);
        bus.gpu_rd_rdy  = 1'b1;
        bus.gpu_data_in = 8'h11;
        cyc();
        chk("o_rdy3", 32'(rd_rdy_out), 32'h8);
        chk("o_d3", 32'(data_out[31:24]), 32'h11);
        bus.gpu_data_in = 8'h22;
        cyc();
        chk("o_rdy1", 32'(rd_rdy_out), 32'h2);
        chk("o_d1", 32'(data_out[15:8]), 32'h22);
        bus.gpu_data_in = 8'h33;
        cyc();
        clr();
        chk("o_rdy0", 32'(rd_rdy_out), 32'h1);
        chk("o_d0", 32'(data_out[7:0]), 32'h33);
        cyc();
        chk("o_cnt0", 32'(rd_outstanding), 32'h0);
        chk("o_all", 32'(data_out), 32'h11002233);

        // return with empty FIFO is an orphan
        bus.gpu_rd_rdy  = 1'b1;
        bus.gpu_data_in = 8'h77;
        cyc();
        clr();
        chk("x_rdy", 32'(rd_rdy_out), 32'h0);
        chk("x_dout", 32'(data_out), 32'h11002233);
        chk("x_orph", 32'(orphan_rdy), 32'h1);
        cyc();
        cyc();
        chk("x_sticky", 32'(orphan_rdy), 32'h1);
        reset = 1'b0;
        #1;
        chk("x_clr", 32'(orphan_rdy), 32'h0);
        cyc();
        reset = 1'b1;

        // reset with a read in flight drops its tag
        rd_req[2] = 1'b1;
        set_port(2, 20'h600, 8'h00);
        cyc();
        clr();
        cyc();
        chk("m_cnt1", 32'(rd_outstanding), 32'h1);
        do_reset();
        chk("m_cnt0", 32'(rd_outstanding), 32'h0);
        bus.gpu_rd_rdy  = 1'b1;
        bus.gpu_data_in = 8'h99;
        cyc();
        clr();
        chk("m_orph", 32'(orphan_rdy), 32'h1);
        chk("m_rdy", 32'(rd_rdy_out), 32'h0);
        chk("m_dout", 32'(data_out), 32'h0);

        // simultaneous write and read strobe: write wins
        do_reset();
        wr_ena[1] = 1'b1;
        rd_req[1] = 1'b1;
        set_port(1, 20'h400, 8'h44);
        cyc();
        clr();
        cyc();
        chk("b_wr", 32'(bus.gpu_wr_ena), 32'h1);
        chk("b_rd", 32'(bus.gpu_rd_req), 32'h0);
        chk("b_addr", 32'(bus.gpu_address), 32'h400);
        chk("b_data", 32'(bus.gpu_data_out), 32'h44);
        cyc();
        chk("b_wr0", 32'(bus.gpu_wr_ena), 32'h0);
        chk("b_rd0", 32'(bus.gpu_rd_req), 32'h0);
        chk("b_cnt", 32'(rd_outstanding), 32'h0);
        chk("b_busy", 32'(port_busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
